tdm_slot_arbiter: RTL and testbench
===================================

// Module: tdm_slot_arbiter
// PURPOSE
//   Round-robin time-slot arbiter sharing one resource among NREQ requesters.
//   A mod-NREQ slot pointer visits each requester in turn. The requester owning
//   the current slot, if requesting, receives an exclusive one-hot grant held
//   until it signals done. Sits between requesting engines and the shared unit.
// PARAMETERS
//   NREQ      3  number of requesters (>=2)
//   PTR_W     2  slot pointer width; must satisfy 2**PTR_W >= NREQ
//   MAX_HOLD  8  watchdog limit in grant cycles (only used with TDM_ARB_WATCHDOG_EN)
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   req       in   NREQ   request per requester, level; held until granted
//   done      in   NREQ   1-cycle release pulse from current owner
//   gnt       out  NREQ   registered one-hot grant; all zero when free
//   gnt_id    out  PTR_W  registered index of owner; valid while busy
//   busy      out  1      1 while in GRANT state
//   slot_tick out  1      1 in IDLE when pointer == 0 (start of a round)
//   timeout   out  1      1-cycle pulse on watchdog revoke; tied 0 without macro
// BEHAVIOUR
//   Reset: state=IDLE, ptr=0, gnt=0, gnt_id=0, busy=0, timeout=0. Applies at once,
//     including mid-grant (gnt drops asynchronously).
//   States: IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10. Any other encoding goes to IDLE.
//   IDLE:
//     - req[ptr]=1 -> GRANT. gnt[ptr]=1 and gnt_id=ptr from the next cycle.
//       Latency req->gnt is 1 clk when the slot matches.
//     - Else ptr advances: ptr==NREQ-1 wraps to 0, else ptr+1. One slot per clk.
//   GRANT:
//     - Exit to RELEASE when done[gnt_id]=1 or req[gnt_id]=0. gnt clears next cycle.
//     - ptr loads gnt_id+1 with the same wrap, so the owner cannot re-win first.
//     - done/req of non-owners are ignored.
//   RELEASE: exactly one dead cycle with gnt=0, then IDLE (no back-to-back grants).
//   Worst-case wait for a waiting requester: NREQ-1 slot steps plus one full hold
//     by each other requester.
//   gnt is never multi-hot. busy = (state==GRANT). slot_tick is combinational from
//     registered state/ptr.
// CONFIGURATION
//   TDM_ARB_WATCHDOG_EN defined:
//     - hold counter clears on entry to GRANT and increments each GRANT cycle.
//     - When the count reaches MAX_HOLD-1 with no release: force RELEASE and pulse
//       timeout for 1 clk. The owner loses the grant after MAX_HOLD grant cycles.
//     - done arriving in the same cycle takes priority: normal release, no timeout.
//   Not defined: no counter; timeout=0; a grant can be held indefinitely.
// STRUCTURE
//   Package tdm_arb_pkg: state typedef/encodings (IDLE/GRANT/RELEASE), default
//     NREQ/PTR_W/MAX_HOLD constants, next-slot wrap function.
//   Sub-module tdm_slot_counter: mod-NREQ pointer with advance enable and
//     synchronous load (used for the owner+1 reload); async reset to 0.
// TESTING
//   1. Reset, req=0 for 9 clk -> ptr cycles 0,1,2,0,...; slot_tick high every 3rd
//      clk; gnt=0.
//   2. req=3'b100 held from reset release -> gnt=3'b100, gnt_id=2 at ptr=2
//      (3rd clk); done[2] pulse -> gnt=0 next clk, 1 RELEASE clk, ptr resumes at 0.
//   3. req=3'b111 held, each owner pulses done after 2 clk -> grant order 0,1,2,0;
//      gnt one-hot every cycle.
//   4. Owner 1 drops req without done -> treated as release; gnt=0 next clk;
//      done[0] pulse from non-owner is ignored.
//   5. Assert reset mid-GRANT -> gnt/busy drop immediately; after release ptr=0,
//      state IDLE.
//   6. With TDM_ARB_WATCHDOG_EN, MAX_HOLD=8: owner never sends done -> gnt high
//      exactly 8 clk, timeout pulses 1 clk, next requester served; without the
//      macro gnt stays high and timeout=0.

Source files
------------

// File: rtl/tdm_slot_arbiter_pkg.sv
// Shared types and constants for the TDM slot arbiter.
// The arbiter's optional hold watchdog is enabled by defining TDM_ARB_WATCHDOG_EN.
package tdm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

  localparam int TDM_NREQ     = 3;
  localparam int TDM_PTR_W    = 2;
  localparam int TDM_MAX_HOLD = 8;

  // Slot that follows cur in a round of nreq slots.
  function automatic int next_slot(input int cur, input int nreq);
    return (cur >= nreq - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/tdm_slot_arbiter_if.sv
// Requester-side bus of the TDM slot arbiter.
// master: the requesting engines; slave: the arbiter.
interface tdm_slot_arbiter_if
  import tdm_arb_pkg::*;
#(
  parameter int NREQ  = TDM_NREQ,
  parameter int PTR_W = TDM_PTR_W
);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  done;
  logic [NREQ-1:0]  gnt;
  logic [PTR_W-1:0] gnt_id;
  logic             busy;
  logic             slot_tick;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, slot_tick, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, slot_tick, timeout
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Mod-NREQ slot pointer: advances one slot per enabled cycle, or loads a
// given slot (load wins over advance).
module tdm_slot_counter
  import tdm_arb_pkg::*;
#(
  parameter int NREQ  = TDM_NREQ,
  parameter int PTR_W = TDM_PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  output logic [PTR_W-1:0] ptr
);

  // Pointer register: reload takes priority over the round-robin step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (load)
      ptr <= load_val;
    else if (adv)
      ptr <= PTR_W'(next_slot(int'(ptr), NREQ));
  end

endmodule

// File: rtl/tdm_slot_arbiter.sv
// Round-robin time-slot arbiter: one exclusive, registered one-hot grant at a
// time, offered to the requester owning the current slot.
// Optional hold watchdog: define TDM_ARB_WATCHDOG_EN.
//
//   state   | meaning
//   IDLE    | scanning slots; grant if the slot owner is requesting
//   GRANT   | owner holds the resource until done or req drop
//   RELEASE | one dead cycle with gnt=0 before scanning resumes
module tdm_slot_arbiter
  import tdm_arb_pkg::*;
#(
  parameter int NREQ     = TDM_NREQ,
  parameter int PTR_W    = TDM_PTR_W,
  parameter int MAX_HOLD = TDM_MAX_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  tdm_slot_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_reload;
  logic             adv, load;
  logic             rel_normal;
  logic             wd_expire;

  // Owner ends its hold by pulsing done or by withdrawing its request.
  assign rel_normal = bus.done[owner_q] | ~bus.req[owner_q];
  assign ptr_reload = PTR_W'(next_slot(int'(owner_q), NREQ));

  tdm_slot_counter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_slot_counter (
    .clk      (clk),
    .reset    (reset),
    .adv      (adv),
    .load     (load),
    .load_val (ptr_reload),
    .ptr      (ptr)
  );

`ifdef TDM_ARB_WATCHDOG_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q;
  logic              tmo_q;

  // Hold timer counts down from MAX_HOLD-1; zero means the last allowed cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hold_q <= '0;
    else if (state_q != GRANT && state_d == GRANT)
      hold_q <= HOLD_W'(MAX_HOLD - 1);
    else if (state_q == GRANT && hold_q != '0)
      hold_q <= hold_q - HOLD_W'(1);
  end

  assign wd_expire = (state_q == GRANT) && (hold_q == '0);

  // Timeout pulses only when the watchdog, not the owner, ends the hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmo_q <= 1'b0;
    else
      tmo_q <= wd_expire & ~rel_normal;
  end

  assign bus.timeout = tmo_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);
  assign wd_expire       = 1'b0;
  assign bus.timeout     = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    adv     = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req[ptr]) begin
          state_d = GRANT;
          owner_d = ptr;
        end else begin
          adv = 1'b1;
        end
      end
      GRANT: begin
        if (rel_normal || wd_expire) begin
          state_d = RELEASE;
          load    = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gnt_d = '0;
    if (state_d == GRANT)
      gnt_d[owner_d] = 1'b1;
  end

  // State, owner and grant registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = owner_q;
  assign bus.busy      = (state_q == GRANT);
  assign bus.slot_tick = (state_q == IDLE) && (ptr == '0);

endmodule

// File: tb/tb_tdm_slot_arbiter.sv
// Self-checking bench for tdm_slot_arbiter: a cycle model pushes expected
// outputs each clock, a negedge monitor pops and compares, and directed
// scenarios add targeted checks.
module tb_tdm_slot_arbiter;
  import tdm_arb_pkg::*;

  localparam int NREQ     = 3;
  localparam int PTR_W    = 2;
  localparam int MAX_HOLD = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  tdm_slot_arbiter_if #(.NREQ(NREQ), .PTR_W(PTR_W)) bus ();

  tdm_slot_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [PTR_W-1:0] gnt_id;
    logic             busy;
    logic             slot_tick;
    logic             timeout;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];

  // Reference model: 0=idle, 1=grant, 2=release.
  int   m_state = 0, m_ptr = 0, m_owner = 0, m_hold = 0;
  bit   m_tmo = 0;
  int   nx_state, nx_ptr, nx_owner, nx_hold;
  bit   nx_tmo;
  exp_t pe;

  always_comb begin
    nx_state = m_state;
    nx_ptr   = m_ptr;
    nx_owner = m_owner;
    nx_hold  = m_hold;
    nx_tmo   = 1'b0;
    if (m_state == 0) begin
      if (bus.req[m_ptr] === 1'b1) begin
        nx_state = 1;
        nx_owner = m_ptr;
        nx_hold  = 0;
      end else begin
        nx_ptr = (m_ptr + 1) % NREQ;
      end
    end else if (m_state == 1) begin
      if (bus.done[m_owner] === 1'b1 || bus.req[m_owner] !== 1'b1) begin
        nx_state = 2;
        nx_ptr   = (m_owner + 1) % NREQ;
      end
`ifdef TDM_ARB_WATCHDOG_EN
      else if (m_hold == MAX_HOLD - 1) begin
        nx_state = 2;
        nx_ptr   = (m_owner + 1) % NREQ;
        nx_tmo   = 1'b1;
      end else begin
        nx_hold = m_hold + 1;
      end
`endif
    end else begin
      nx_state = 0;
    end
    pe.gnt = '0;
    if (nx_state == 1)
      pe.gnt[nx_owner] = 1'b1;
    pe.gnt_id    = PTR_W'(nx_owner);
    pe.busy      = (nx_state == 1);
    pe.slot_tick = (nx_state == 0) && (nx_ptr == 0);
    pe.timeout   = nx_tmo;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= 0;
      m_ptr   <= 0;
      m_owner <= 0;
      m_hold  <= 0;
      m_tmo   <= 1'b0;
      exp_q.delete();
    end else begin
      m_state <= nx_state;
      m_ptr   <= nx_ptr;
      m_owner <= nx_owner;
      m_hold  <= nx_hold;
      m_tmo   <= nx_tmo;
      exp_q.push_back(pe);
    end
  end

  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.busy && !prev_busy)
        grant_log.push_back(int'(bus.gnt_id));
      prev_busy <= bus.busy;
      check_eq("onehot", 32'($onehot0(bus.gnt)), 32'd1);
      if (exp_q.size() > 0) begin
        check_eq("sb_gnt",       32'(bus.gnt),       32'(exp_q[0].gnt));
        check_eq("sb_busy",      32'(bus.busy),      32'(exp_q[0].busy));
        check_eq("sb_slot_tick", 32'(bus.slot_tick), 32'(exp_q[0].slot_tick));
        check_eq("sb_timeout",   32'(bus.timeout),   32'(exp_q[0].timeout));
        if (exp_q[0].busy)
          check_eq("sb_gnt_id", 32'(bus.gnt_id), 32'(exp_q[0].gnt_id));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    bus.req  = '0;
    bus.done = '0;
    reset    = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_gnt",       32'(bus.gnt),       32'd0);
    check_eq("rst_gnt_id",    32'(bus.gnt_id),    32'd0);
    check_eq("rst_busy",      32'(bus.busy),      32'd0);
    check_eq("rst_timeout",   32'(bus.timeout),   32'd0);
    check_eq("rst_slot_tick", 32'(bus.slot_tick), 32'd1);
  endtask

  task automatic wait_busy(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.busy) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    ok = bus.busy;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int ticks, lat, held0, tmo_cnt, seen_g1;
    bit ok;
    int exp_order[4];
    exp_order = '{0, 1, 2, 0};
    bus.req  = '0;
    bus.done = '0;

    // 1: idle scan
    do_reset();
    ticks = 0;
    repeat (9) begin
      step();
      if (bus.slot_tick) ticks++;
    end
    check_eq("t1_ticks", 32'(ticks), 32'd3);
    check_eq("t1_gnt", 32'(bus.gnt), 32'd0);

    // 2: single requester at slot 2
    do_reset();
    bus.req = 3'b100;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.busy) begin
        lat = i;
        break;
      end
    end
    check_eq("t2_latency", 32'(lat), 32'd3);
    check_eq("t2_gnt", 32'(bus.gnt), 32'b100);
    check_eq("t2_gnt_id", 32'(bus.gnt_id), 32'd2);
    step();
    bus.done = 3'b100;
    bus.req  = 3'b000;
    step();
    bus.done = '0;
    check_eq("t2_gnt_off", 32'(bus.gnt), 32'd0);
    check_eq("t2_release_busy", 32'(bus.busy), 32'd0);
    check_eq("t2_release_tick", 32'(bus.slot_tick), 32'd0);
    step();
    check_eq("t2_ptr_resume", 32'(bus.slot_tick), 32'd1);

    // 3: all requesting, round-robin order
    do_reset();
    grant_log.delete();
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_busy(10, ok);
      check_eq("t3_wait_busy", 32'(ok), 32'd1);
      if (!ok) break;
      step();
      step();
      bus.done = '0;
      bus.done[bus.gnt_id] = 1'b1;
      step();
      bus.done = '0;
    end
    bus.req = '0;
    step();
    step();
    check_eq("t3_grant_count", 32'(grant_log.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++)
      if (grant_log.size() > k)
        check_eq("t3_order", 32'(grant_log[k]), 32'(exp_order[k]));

    // 4: req drop releases; non-owner done ignored
    do_reset();
    bus.req = 3'b010;
    wait_busy(10, ok);
    check_eq("t4_wait_busy", 32'(ok), 32'd1);
    check_eq("t4_gnt_id", 32'(bus.gnt_id), 32'd1);
    step();
    bus.done = 3'b001;
    step();
    bus.done = '0;
    check_eq("t4_nonowner_done", 32'(bus.busy), 32'd1);
    check_eq("t4_gnt_held", 32'(bus.gnt), 32'b010);
    bus.req = '0;
    step();
    check_eq("t4_req_drop", 32'(bus.gnt), 32'd0);
    check_eq("t4_busy_drop", 32'(bus.busy), 32'd0);

    // 5: reset mid-grant
    do_reset();
    bus.req = 3'b001;
    wait_busy(10, ok);
    check_eq("t5_wait_busy", 32'(ok), 32'd1);
    step();
    #1;
    reset = 1'b1;
    #1;
    check_eq("t5_async_gnt", 32'(bus.gnt), 32'd0);
    check_eq("t5_async_busy", 32'(bus.busy), 32'd0);
    bus.req = '0;
    step();
    step();
    reset = 1'b0;
    check_eq("t5_post_tick", 32'(bus.slot_tick), 32'd1);
    check_eq("t5_post_busy", 32'(bus.busy), 32'd0);
    step();
    check_eq("t5_ptr_adv", 32'(bus.slot_tick), 32'd0);

    // 6: owner never releases
    do_reset();
    bus.req = 3'b011;
    wait_busy(10, ok);
    check_eq("t6_wait_busy", 32'(ok), 32'd1);
    check_eq("t6_gnt_id", 32'(bus.gnt_id), 32'd0);
    held0   = 0;
    tmo_cnt = 0;
    seen_g1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.gnt == 3'b001) held0++;
      if (bus.gnt == 3'b010) seen_g1 = 1;
      if (bus.timeout) tmo_cnt++;
      step();
    end
`ifdef TDM_ARB_WATCHDOG_EN
    check_eq("t6_hold_cycles", 32'(held0), 32'(MAX_HOLD));
    check_eq("t6_timeout_pulses", 32'(tmo_cnt), 32'd1);
    check_eq("t6_next_served", 32'(seen_g1), 32'd1);
`else
    check_eq("t6_hold_cycles", 32'(held0), 32'd12);
    check_eq("t6_timeout_pulses", 32'(tmo_cnt), 32'd0);
    check_eq("t6_next_served", 32'(seen_g1), 32'd0);
`endif
    bus.req = '0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
